legv8_mc_ctrl: RTL and testbench
================================

# legv8_mc_ctrl

Multicycle sequencer for the LEGv8 core. It replaces the single-cycle combinational control path with a Moore state machine that steps the shared datapath through the fetch, decode, execute, memory and writeback phases. It uses a single unified memory port with a ready handshake, so variable-latency memory is supported. It sits beside the datapath in the top level, takes `opcode` from the instruction register and drives every datapath control line.

## Interface
- `MAX_WAIT`, default 0: memory-wait watchdog limit in cycles. 0 disables the watchdog.
- `clk` in 1: clock. Everything is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `opcode` in 11: instruction bits [31:21] from the IR. Valid from DECODE onward.
- `mem_ready` in 1: memory access completes this cycle.
- `PCWrite` out 1: unconditional PC load.
- `IRWrite` out 1: IR load.
- `IorD` out 1: memory address select. 0 selects PC, 1 selects ALUOut.
- `Reg2Loc` out 1: read-register-2 select. 1 selects Rt.
- `RegWrite` out 1: register-file write.
- `ALUSrcA` out 1: ALU A operand. 0 selects PC, 1 selects reg A.
- `ALUSrcB` out 2: ALU B operand. 00 reg B, 01 const 4, 10 sign-extended immediate, 11 immediate<<2.
- `ALUOp` out 2: 00 add, 01 pass B (CB test), 10 R-type function.
- `SregUp` out 1: flags update.
- `BranchOp` out 3: 000 none, 001 B, 010 CBZ, 011 CBNZ, 100 B.cond. The datapath loads ALUOut into PC when its condition holds.
- `MemRead` out 1, `MemWrite` out 1: memory strobes.
- `MemtoReg` out 2: 00 ALUOut, 01 MDR.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `fault` out 1: sticky. Set by an illegal opcode or a watchdog expiry.

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, BRANCH, FAULT. All outputs are Moore outputs decoded from the state and the latched class. Any output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: `MemRead=1`, `IorD=0`, `ALUSrcA=0`, `ALUSrcB=01`, `ALUOp=00`.
  - While `mem_ready=0`, stay in FETCH.
  - When `mem_ready=1`: `IRWrite=1` and `PCWrite=1` in that same cycle (PC+4), then go to DECODE.
- DECODE: `ALUSrcA=0`, `ALUSrcB=11`, `ALUOp=00`, so the branch target goes to ALUOut. `Reg2Loc=1` for STUR/CBZ/CBNZ.
  - The opcode class is latched this cycle.
  - Next state: BRANCH for B, CBZ, CBNZ, B.cond. FAULT for an illegal opcode. EXEC for everything else.
- EXEC:
  - R-type: `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=10`. ADDS/SUBS also assert `SregUp=1`. Next state WB.
  - ADDI/SUBI: `ALUSrcA=1`, `ALUSrcB=10`, `ALUOp=10`. Next state WB.
  - LDUR/STUR: `ALUSrcA=1`, `ALUSrcB=10`, `ALUOp=00`. Next state MEM.
- MEM: `IorD=1`. LDUR asserts `MemRead`, STUR asserts `MemWrite`, `Reg2Loc=1` for STUR.
  - Strobes are held until `mem_ready=1`.
  - On `mem_ready=1`: LDUR goes to WB. STUR asserts `retire` and goes to FETCH.
- WB: `RegWrite=1`. `MemtoReg` is 01 for LDUR and 00 otherwise. `retire=1`. Next state FETCH.
- BRANCH: `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=01`, `BranchOp` set from the class, `retire=1`. Next state FETCH.
- FAULT: `fault=1`, all other outputs 0. Only `rst` leaves this state.
- Legal opcodes: ADD, SUB, AND, ORR, ADDS, SUBS, ADDI, SUBI, LDUR, STUR, CBZ, CBNZ, B, B.cond.

## Timing
- Cycles per instruction with zero-wait memory (`mem_ready` held at 1): R-type and I-type 4, LDUR 5, STUR 4, branches 3.
- Each memory wait cycle adds exactly 1 cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- The wait counter is 16 bits. It clears on entry to FETCH and MEM. With `MAX_WAIT>0`, reaching `MAX_WAIT` consecutive wait cycles sends the controller to FAULT on the next edge.
- Reset:
  - `rst` high has priority over every transition. The next state is RESET, so all outputs are 0 one cycle later.
  - A memory access in progress is abandoned. A pending writeback is never performed.
- `retire` rises in exactly one cycle per instruction and never in RESET or FAULT.
- A `mem_ready=1` in the same cycle as `rst=1` is discarded.

## Structure
- `common.vh` holds:
  - state encodings `S_RESET`…`S_FAULT`
  - the 11-bit opcode constants, with don't-care masks for the I-type, CB and B formats
  - the class codes
  - the `BranchOp`, `ALUOp` and `ALUSrcB` encodings, shared with the datapath
- Sub-module `inst_class_dec`: purely combinational, maps opcode to class and `illegal`.

## Test plan
- Reset, then an ADD opcode with `mem_ready=1`:
  - the state sequence after `rst` falls is RESET, FETCH, DECODE, EXEC, WB
  - `RegWrite=1` and `retire=1` at cycle 5
  - `SregUp=0` throughout
- LDUR (11111000010) with 2 wait cycles in FETCH and 3 in MEM:
  - `MemRead` stays high for 3 FETCH cycles, then for 4 MEM cycles
  - `MemtoReg=01` in WB
  - `retire` after 10 cycles
- STUR:
  - `MemWrite=1` with `IorD=1` and `Reg2Loc=1`
  - `retire` in the MEM cycle where `mem_ready=1`
  - no `RegWrite` at any point
- CBNZ (10110101xxx):
  - `BranchOp=011` and `retire` in cycle 3, then FETCH
  - SUBS asserts `SregUp` in EXEC only
- Opcode 11111111111:
  - DECODE goes to FAULT and `fault` stays high for 20 cycles
  - `rst` clears it, and the controller fetches again
- `MAX_WAIT=4` with `mem_ready` held at 0 in FETCH goes to FAULT after 4 wait cycles. Separately, `rst` asserted mid-MEM on a STUR gives `MemWrite=0` on the next cycle and no `retire`.

Source files
------------

// File: rtl/legv8_mc_ctrl_pkg.sv
// Shared encodings for the LEGv8 multicycle controller and its datapath.
package legv8_mc_ctrl_pkg;

  localparam int unsigned OPC_W = 11;
  localparam int unsigned CNT_W = 16;

  // Controller states
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // Instruction classes resolved from the opcode field
  typedef enum logic [3:0] {
    CL_RTYPE   = 4'd0,
    CL_RTYPE_S = 4'd1,
    CL_ITYPE   = 4'd2,
    CL_LDUR    = 4'd3,
    CL_STUR    = 4'd4,
    CL_CBZ     = 4'd5,
    CL_CBNZ    = 4'd6,
    CL_B       = 4'd7,
    CL_BCOND   = 4'd8,
    CL_ILLEGAL = 4'd9
  } inst_class_t;

  // Opcode patterns (bits [31:21]) and don't-care masks
  localparam logic [OPC_W-1:0] OPC_ADD   = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB   = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND   = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR   = 11'b10101010000;
  localparam logic [OPC_W-1:0] OPC_ADDS  = 11'b10101011000;
  localparam logic [OPC_W-1:0] OPC_SUBS  = 11'b11101011000;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 11'b10010001000;
  localparam logic [OPC_W-1:0] OPC_SUBI  = 11'b11010001000;
  localparam logic [OPC_W-1:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [OPC_W-1:0] OPC_STUR  = 11'b11111000000;
  localparam logic [OPC_W-1:0] OPC_CBZ   = 11'b10110100000;
  localparam logic [OPC_W-1:0] OPC_CBNZ  = 11'b10110101000;
  localparam logic [OPC_W-1:0] OPC_B     = 11'b00010100000;
  localparam logic [OPC_W-1:0] OPC_BCOND = 11'b01010100000;

  localparam logic [OPC_W-1:0] MASK_FULL = 11'b11111111111;
  localparam logic [OPC_W-1:0] MASK_I    = 11'b11111111110;
  localparam logic [OPC_W-1:0] MASK_CB   = 11'b11111111000;
  localparam logic [OPC_W-1:0] MASK_B    = 11'b11111100000;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // Branch kind driven to the PC-update logic
  localparam logic [2:0] BR_NONE  = 3'b000;
  localparam logic [2:0] BR_B     = 3'b001;
  localparam logic [2:0] BR_CBZ   = 3'b010;
  localparam logic [2:0] BR_CBNZ  = 3'b011;
  localparam logic [2:0] BR_BCOND = 3'b100;

  // Writeback source select
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;

  // Full set of datapath control lines for one cycle
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       reg2loc;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       sreg_up;
    logic [2:0] branch_op;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       retire;
    logic       fault;
  } ctrl_t;

  // True when opc equals pat on every bit set in mask
  function automatic logic opc_match(input logic [OPC_W-1:0] opc,
                                     input logic [OPC_W-1:0] pat,
                                     input logic [OPC_W-1:0] mask);
    return ((opc ^ pat) & mask) == '0;
  endfunction

endpackage

// File: rtl/legv8_mc_ctrl_inst_class_dec.sv
// Combinational opcode classifier for the multicycle controller.
module legv8_mc_ctrl_inst_class_dec
  import legv8_mc_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output inst_class_t      inst_class,
  output logic             illegal
);

  // Priority-free match: the legal patterns are mutually exclusive
  always_comb begin
    inst_class = CL_ILLEGAL;
    if (opc_match(opcode, OPC_ADD, MASK_FULL) ||
        opc_match(opcode, OPC_SUB, MASK_FULL) ||
        opc_match(opcode, OPC_AND, MASK_FULL) ||
        opc_match(opcode, OPC_ORR, MASK_FULL)) begin
      inst_class = CL_RTYPE;
    end else if (opc_match(opcode, OPC_ADDS, MASK_FULL) ||
                 opc_match(opcode, OPC_SUBS, MASK_FULL)) begin
      inst_class = CL_RTYPE_S;
    end else if (opc_match(opcode, OPC_ADDI, MASK_I) ||
                 opc_match(opcode, OPC_SUBI, MASK_I)) begin
      inst_class = CL_ITYPE;
    end else if (opc_match(opcode, OPC_LDUR, MASK_FULL)) begin
      inst_class = CL_LDUR;
    end else if (opc_match(opcode, OPC_STUR, MASK_FULL)) begin
      inst_class = CL_STUR;
    end else if (opc_match(opcode, OPC_CBZ, MASK_CB)) begin
      inst_class = CL_CBZ;
    end else if (opc_match(opcode, OPC_CBNZ, MASK_CB)) begin
      inst_class = CL_CBNZ;
    end else if (opc_match(opcode, OPC_BCOND, MASK_CB)) begin
      inst_class = CL_BCOND;
    end else if (opc_match(opcode, OPC_B, MASK_B)) begin
      inst_class = CL_B;
    end
    illegal = (inst_class == CL_ILLEGAL);
  end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// LEGv8 multicycle sequencer: Moore FSM stepping the shared datapath
// through fetch/decode/execute/memory/writeback over one memory port.
module legv8_mc_ctrl
  import legv8_mc_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             Reg2Loc,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             SregUp,
  output logic [2:0]       BranchOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       MemtoReg,
  output logic             retire,
  output logic             fault
);

  state_t           state;
  state_t           state_next;
  inst_class_t      cls_q;
  inst_class_t      cls_dec;
  logic             illegal;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_done_c;
  logic             wd_hit_c;
  logic             is_mem_cls_c;
  ctrl_t            ctrl;

  legv8_mc_ctrl_inst_class_dec u_inst_class_dec (
    .opcode     (opcode),
    .inst_class (cls_dec),
    .illegal    (illegal)
  );

  // A ready seen while reset is asserted must not complete any access
  assign mem_done_c   = mem_ready & ~rst;
  assign is_mem_cls_c = (cls_q == CL_LDUR) || (cls_q == CL_STUR);

  // Watchdog trips on the MAX_WAIT-th consecutive wait cycle
  assign wd_hit_c = (MAX_WAIT != 32'd0) && !mem_ready &&
                    (wait_cnt == CNT_W'(MAX_WAIT - 32'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Latch the instruction class while the IR is being decoded
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_q <= CL_ILLEGAL;
    end else if (state == S_DECODE) begin
      cls_q <= cls_dec;
    end
  end

  // Consecutive memory-wait counter, cleared on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if ((state == S_FETCH || state == S_MEM) && !mem_ready &&
                 (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)     state_next = S_DECODE;
        else if (wd_hit_c) state_next = S_FAULT;
      end
      S_DECODE: begin
        if (illegal) begin
          state_next = S_FAULT;
        end else if (cls_dec == CL_B || cls_dec == CL_CBZ ||
                     cls_dec == CL_CBNZ || cls_dec == CL_BCOND) begin
          state_next = S_BRANCH;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC:   state_next = is_mem_cls_c ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready)     state_next = (cls_q == CL_LDUR) ? S_WB : S_FETCH;
        else if (wd_hit_c) state_next = S_FAULT;
      end
      S_WB:     state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_RESET;
    endcase
  end

  // Control decode from state and latched class
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_done_c;
        ctrl.pc_write  = mem_done_c;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_S2;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.reg2loc   = (cls_dec == CL_STUR) || (cls_dec == CL_CBZ) ||
                         (cls_dec == CL_CBNZ);
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        case (cls_q)
          CL_RTYPE, CL_RTYPE_S: begin
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_RTYPE;
            ctrl.sreg_up   = (cls_q == CL_RTYPE_S);
          end
          CL_ITYPE: begin
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_RTYPE;
          end
          default: begin
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
          end
        endcase
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (cls_q == CL_LDUR);
        ctrl.mem_write = (cls_q == CL_STUR);
        ctrl.reg2loc   = (cls_q == CL_STUR);
        ctrl.retire    = (cls_q == CL_STUR) && mem_done_c;
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (cls_q == CL_LDUR) ? M2R_MDR : M2R_ALU;
        ctrl.retire     = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_PASSB;
        ctrl.retire    = 1'b1;
        case (cls_q)
          CL_B:     ctrl.branch_op = BR_B;
          CL_CBZ:   ctrl.branch_op = BR_CBZ;
          CL_CBNZ:  ctrl.branch_op = BR_CBNZ;
          CL_BCOND: ctrl.branch_op = BR_BCOND;
          default:  ctrl.branch_op = BR_NONE;
        endcase
      end
      S_FAULT: ctrl.fault = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign PCWrite  = ctrl.pc_write;
  assign IRWrite  = ctrl.ir_write;
  assign IorD     = ctrl.i_or_d;
  assign Reg2Loc  = ctrl.reg2loc;
  assign RegWrite = ctrl.reg_write;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign SregUp   = ctrl.sreg_up;
  assign BranchOp = ctrl.branch_op;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign MemtoReg = ctrl.mem_to_reg;
  assign retire   = ctrl.retire;
  assign fault    = ctrl.fault;

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Scoreboard bench for legv8_mc_ctrl: per-cycle expected control vectors.
module tb_legv8_mc_ctrl;

  logic        clk;
  logic        rst;
  logic [10:0] opcode;
  logic        mem_ready;
  logic        PCWrite, IRWrite, IorD, Reg2Loc, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, MemtoReg;
  logic        SregUp, MemRead, MemWrite, retire, fault;
  logic [2:0]  BranchOp;

  legv8_mc_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .Reg2Loc(Reg2Loc),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .SregUp(SregUp), .BranchOp(BranchOp), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .retire(retire), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: PCWrite IRWrite IorD Reg2Loc RegWrite ALUSrcA | ALUSrcB |
  // ALUOp | SregUp | BranchOp | MemRead MemWrite | MemtoReg | retire fault
  localparam logic [19:0] E_ZERO   = 20'd0;
  localparam logic [19:0] E_F_W    = {6'b000000, 2'b01, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_F_R    = {6'b110000, 2'b01, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_D      = {6'b000000, 2'b11, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_D_R2L  = {6'b000100, 2'b11, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_X_R    = {6'b000001, 2'b00, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_X_RS   = {6'b000001, 2'b00, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_X_I    = {6'b000001, 2'b10, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_X_M    = {6'b000001, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_M_LD   = {6'b001000, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_M_ST_W = {6'b001100, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
  localparam logic [19:0] E_M_ST_R = {6'b001100, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0};
  localparam logic [19:0] E_WB_A   = {6'b000010, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
  localparam logic [19:0] E_WB_M   = {6'b000010, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
  localparam logic [19:0] E_BR_B   = {6'b000001, 2'b00, 2'b01, 1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
  localparam logic [19:0] E_BR_CBZ = {6'b000001, 2'b00, 2'b01, 1'b0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
  localparam logic [19:0] E_BR_CBN = {6'b000001, 2'b00, 2'b01, 1'b0, 3'b011, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
  localparam logic [19:0] E_BR_BC  = {6'b000001, 2'b00, 2'b01, 1'b0, 3'b100, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
  localparam logic [19:0] E_FLT    = 20'd1;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_CBNZ = 11'b10110101011;
  localparam logic [10:0] OP_B    = 11'b00010110110;
  localparam logic [10:0] OP_BC   = 11'b01010100001;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          failures;
  logic        finish_req;

  // One cycle of stimulus; the expected outputs for that cycle are queued
  task automatic step(input logic r, input logic [10:0] op, input logic rdy,
                      input logic [19:0] exp, input string nm);
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Monitor: compares the DUT outputs against the queue head every cycle
  always @(negedge clk) begin
    logic [19:0] act;
    logic [19:0] exp;
    string       nm;
    act = {PCWrite, IRWrite, IorD, Reg2Loc, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           SregUp, BranchOp, MemRead, MemWrite, MemtoReg, retire, fault};
    if (finish_req) begin
      if (exp_q.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL %s @%0t: got %b required %b", nm, $time, act, exp);
      end
    end
  end

  initial begin
    checks     = 0;
    failures   = 0;
    finish_req = 1'b0;
    rst        = 1'b1;
    opcode     = '0;
    mem_ready  = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, OP_ADD, 1'b1, E_ZERO, "reset_hold");

    // ADD, zero-wait memory: RESET FETCH DECODE EXEC WB
    step(1'b0, OP_ADD, 1'b1, E_ZERO, "add_reset");
    step(1'b0, OP_ADD, 1'b1, E_F_R,  "add_fetch");
    step(1'b0, OP_ADD, 1'b1, E_D,    "add_decode");
    step(1'b0, OP_ADD, 1'b1, E_X_R,  "add_exec");
    step(1'b0, OP_ADD, 1'b1, E_WB_A, "add_wb");

    // LDUR: 2 fetch waits, 3 mem waits, 10 cycles total
    step(1'b0, OP_LDUR, 1'b0, E_F_W,  "ldur_fetch_w0");
    step(1'b0, OP_LDUR, 1'b0, E_F_W,  "ldur_fetch_w1");
    step(1'b0, OP_LDUR, 1'b1, E_F_R,  "ldur_fetch_rdy");
    step(1'b0, OP_LDUR, 1'b1, E_D,    "ldur_decode");
    step(1'b0, OP_LDUR, 1'b1, E_X_M,  "ldur_exec");
    for (int i = 0; i < 3; i++) step(1'b0, OP_LDUR, 1'b0, E_M_LD, "ldur_mem_wait");
    step(1'b0, OP_LDUR, 1'b1, E_M_LD, "ldur_mem_rdy");
    step(1'b0, OP_LDUR, 1'b1, E_WB_M, "ldur_wb");

    // STUR with one mem wait; retires in the ready MEM cycle
    step(1'b0, OP_STUR, 1'b1, E_F_R,    "stur_fetch");
    step(1'b0, OP_STUR, 1'b1, E_D_R2L,  "stur_decode");
    step(1'b0, OP_STUR, 1'b1, E_X_M,    "stur_exec");
    step(1'b0, OP_STUR, 1'b0, E_M_ST_W, "stur_mem_wait");
    step(1'b0, OP_STUR, 1'b1, E_M_ST_R, "stur_mem_rdy");

    // Branches: 3 cycles each
    step(1'b0, OP_CBNZ, 1'b1, E_F_R,    "cbnz_fetch");
    step(1'b0, OP_CBNZ, 1'b1, E_D_R2L,  "cbnz_decode");
    step(1'b0, OP_CBNZ, 1'b1, E_BR_CBN, "cbnz_branch");
    step(1'b0, OP_CBZ,  1'b1, E_F_R,    "cbz_fetch");
    step(1'b0, OP_CBZ,  1'b1, E_D_R2L,  "cbz_decode");
    step(1'b0, OP_CBZ,  1'b1, E_BR_CBZ, "cbz_branch");
    step(1'b0, OP_B,    1'b1, E_F_R,    "b_fetch");
    step(1'b0, OP_B,    1'b1, E_D,      "b_decode");
    step(1'b0, OP_B,    1'b1, E_BR_B,   "b_branch");
    step(1'b0, OP_BC,   1'b1, E_F_R,    "bcond_fetch");
    step(1'b0, OP_BC,   1'b1, E_D,      "bcond_decode");
    step(1'b0, OP_BC,   1'b1, E_BR_BC,  "bcond_branch");

    // SUBS: flags only in EXEC; mem_ready low outside FETCH is ignored
    step(1'b0, OP_SUBS, 1'b1, E_F_R,  "subs_fetch");
    step(1'b0, OP_SUBS, 1'b0, E_D,    "subs_decode");
    step(1'b0, OP_SUBS, 1'b0, E_X_RS, "subs_exec");
    step(1'b0, OP_SUBS, 1'b0, E_WB_A, "subs_wb");

    // ADDI (low opcode bit is don't-care) and ORR
    step(1'b0, OP_ADDI, 1'b1, E_F_R,  "addi_fetch");
    step(1'b0, OP_ADDI, 1'b1, E_D,    "addi_decode");
    step(1'b0, OP_ADDI, 1'b1, E_X_I,  "addi_exec");
    step(1'b0, OP_ADDI, 1'b1, E_WB_A, "addi_wb");
    step(1'b0, OP_ORR,  1'b1, E_F_R,  "orr_fetch");
    step(1'b0, OP_ORR,  1'b1, E_D,    "orr_decode");
    step(1'b0, OP_ORR,  1'b1, E_X_R,  "orr_exec");
    step(1'b0, OP_ORR,  1'b1, E_WB_A, "orr_wb");

    // Illegal opcode: sticky FAULT until reset, then fetch resumes
    step(1'b0, OP_ILL, 1'b1, E_F_R, "ill_fetch");
    step(1'b0, OP_ILL, 1'b1, E_D,   "ill_decode");
    for (int i = 0; i < 20; i++) step(1'b0, OP_ILL, i[0], E_FLT, "ill_fault_hold");
    step(1'b1, OP_ADD, 1'b1, E_FLT,  "ill_rst_cycle");
    step(1'b0, OP_ADD, 1'b1, E_ZERO, "ill_after_rst");
    step(1'b0, OP_ADD, 1'b0, E_F_W,  "ill_refetch");
    step(1'b0, OP_ADD, 1'b1, E_F_R,  "ill_refetch_rdy");
    step(1'b0, OP_ADD, 1'b1, E_D,    "ill_refetch_dec");

    // Reset mid-MEM on STUR with a simultaneous ready: no retire, no write
    step(1'b0, OP_ADD,  1'b1, E_X_R,    "pre_exec");
    step(1'b0, OP_ADD,  1'b1, E_WB_A,   "pre_wb");
    step(1'b0, OP_STUR, 1'b1, E_F_R,    "rst_stur_fetch");
    step(1'b0, OP_STUR, 1'b1, E_D_R2L,  "rst_stur_decode");
    step(1'b0, OP_STUR, 1'b1, E_X_M,    "rst_stur_exec");
    step(1'b0, OP_STUR, 1'b0, E_M_ST_W, "rst_stur_mem_wait");
    step(1'b1, OP_STUR, 1'b1, E_M_ST_W, "rst_stur_mem_rst");
    step(1'b0, OP_STUR, 1'b1, E_ZERO,   "rst_stur_after");

    // Watchdog: 4 consecutive fetch waits lead to FAULT
    for (int i = 0; i < 4; i++) step(1'b0, OP_ADD, 1'b0, E_F_W, "wd_fetch_wait");
    step(1'b0, OP_ADD, 1'b0, E_FLT, "wd_fault");
    step(1'b0, OP_ADD, 1'b1, E_FLT, "wd_fault_hold");
    step(1'b1, OP_ADD, 1'b0, E_FLT, "wd_rst_cycle");
    step(1'b0, OP_ADD, 1'b0, E_ZERO, "wd_after_rst");
    step(1'b0, OP_ADD, 1'b1, E_F_R,  "wd_refetch");

    @(posedge clk);
    @(posedge clk);
    #1;
    finish_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL timeout: monitor did not reach summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
